// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared FSM encoding and sizing helpers for the instruction loader
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNT_HI = 3'd1,
    ST_COUNT_LO = 3'd2,
    ST_DATA     = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  localparam int HEADER_W = 16;

  function automatic int bytes_per_word(input int size);
    return size / 8;
  endfunction

  // A one-byte word still gets a 1-bit counter so the port never collapses to zero width.
  function automatic int byte_cnt_w(input int size);
    return (size / 8 > 1) ? $clog2(size / 8) : 1;
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// rtl/instruction_loader_word_assembler.sv - big-endian byte packer with a wrapping byte counter
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byteFire,
  input  logic [7:0]      byteIn,
  output logic [size-1:0] word,
  output logic            wordComplete
);

  localparam int BPW = bytes_per_word(size);
  localparam int CW  = byte_cnt_w(size);

  logic [CW-1:0] count_q, count_d;
  logic          last_byte;

  assign last_byte    = (count_q == CW'(BPW - 1));
  assign wordComplete = byteFire && !clear && last_byte;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (byteFire) begin
      count_d = last_byte ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Only the first BPW-1 bytes are stored; the final byte is spliced in live so the
  // completed word is available on the same edge that accepts its last byte.
  generate
    if (size == 8) begin : g_single
      assign word = byteIn;
    end else begin : g_shift
      logic [size-9:0] shift_q, shift_d;
      if (size == 16) begin : g_one
        assign shift_d = byteIn;
      end else begin : g_many
        assign shift_d = {shift_q[size-17:0], byteIn};
      end
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          shift_q <= '0;
        end else if (byteFire) begin
          shift_q <= shift_d;
        end
      end
      assign word = {shift_q, byteIn};
    end
  endgenerate

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot-time streaming writer for instruction memory
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int size   = 32,
  parameter int length = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                byteIn,
  input  logic                      byteValid,
  output logic                      byteReady,
  output logic                      memWriteEnable,
  output logic [$clog2(length)-1:0] memAddress,
  output logic [size-1:0]           memWriteData,
  output logic                      holdCpu,
  output logic                      loadDone,
  output logic                      loadError
);

  localparam int AW = $clog2(length);
  localparam int IW = $clog2(length + 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [7:0]            hi_q, hi_d;
  logic [HEADER_W-1:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [size-1:0]       data_q, data_d;

  logic                  fire;
  logic                  asm_clear;
  logic                  asm_fire;
  logic                  word_complete;
  logic [size-1:0]       asm_word;
  logic [HEADER_W-1:0]   header;

  assign byteReady = (state_q == ST_COUNT_HI) || (state_q == ST_COUNT_LO) || (state_q == ST_DATA);
  assign fire      = byteValid && byteReady;
  assign asm_fire  = fire && (state_q == ST_DATA);
  assign header    = {hi_q, byteIn};

  word_assembler #(.size(size)) u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (asm_clear),
    .byteFire     (asm_fire),
    .byteIn       (byteIn),
    .word         (asm_word),
    .wordComplete (word_complete)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    hi_d      = hi_q;
    count_d   = count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_COUNT_HI;
          index_d   = '0;
          asm_clear = 1'b1;
        end
      end
      ST_COUNT_HI: begin
        if (fire) begin
          hi_d    = byteIn;
          state_d = ST_COUNT_LO;
        end
      end
      ST_COUNT_LO: begin
        if (fire) begin
          count_d = header;
          if (header == '0) begin
            state_d = ST_DONE;
          end else if (32'(header) > 32'(length)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_complete) begin
          we_d    = 1'b1;
          addr_d  = index_q[AW-1:0];
          data_d  = asm_word;
          index_d = index_q + IW'(1);
          if (32'(index_q) + 32'd1 == 32'(count_q)) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Reset also drops any write strobe staged on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      hi_q    <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memWriteData   = data_q;
  assign holdCpu        = (state_q != ST_DONE);
  assign loadDone       = (state_q == ST_DONE);
  assign loadError      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized self-checking bench for instruction_loader
module tb_instruction_loader;

  localparam int SIZE   = 32;
  localparam int LENGTH = 256;
  localparam int AW     = $clog2(LENGTH);
  localparam int BPW    = SIZE / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      byteIn = 8'h00;
  logic            byteValid = 1'b0;
  logic            byteReady;
  logic            memWriteEnable;
  logic [AW-1:0]   memAddress;
  logic [SIZE-1:0] memWriteData;
  logic            holdCpu;
  logic            loadDone;
  logic            loadError;

  instruction_loader #(.size(SIZE), .length(LENGTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .byteIn         (byteIn),
    .byteValid      (byteValid),
    .byteReady      (byteReady),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .holdCpu        (holdCpu),
    .loadDone       (loadDone),
    .loadError      (loadError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]      tx_q[$];
  int              acc_q[$];
  int              wr_addr[$];
  logic [SIZE-1:0] wr_data[$];
  int              wr_cyc[$];
  int              back_to_back = 0;
  bit              prev_we = 1'b0;

  always @(negedge clk) begin
    if (memWriteEnable === 1'b1) begin
      wr_addr.push_back(int'(memAddress));
      wr_data.push_back(memWriteData);
      wr_cyc.push_back(cyc);
      if (prev_we) back_to_back++;
    end
    prev_we = (memWriteEnable === 1'b1);
  end

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_holdCpu"}, holdCpu, 1);
    expect_eq({tag, "_byteReady"}, byteReady, 0);
    expect_eq({tag, "_memWriteEnable"}, memWriteEnable, 0);
    expect_eq({tag, "_memAddress"}, memAddress, 0);
    expect_eq({tag, "_memWriteData"}, memWriteData, 0);
    expect_eq({tag, "_loadDone"}, loadDone, 0);
    expect_eq({tag, "_loadError"}, loadError, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers each byte of tx_q, idling byteValid stall_pct percent of the time, and
  // records the edge on which each byte is accepted.
  task automatic send_stream(input int stall_pct);
    for (int i = 0; i < tx_q.size(); i++) begin
      int  waited = 0;
      bit  taken = 1'b0;
      while (!taken) begin
        @(negedge clk);
        byteIn    = tx_q[i];
        byteValid = ($urandom_range(99) >= stall_pct);
        if (byteValid && byteReady) begin
          acc_q.push_back(cyc + 1);
          taken = 1'b1;
        end else if (++waited > 400) begin
          expect_eq("byte_accept_timeout", i, tx_q.size());
          byteValid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic load(input string tag, input int stall_pct);
    int n;
    int done_cyc;
    int t;
    pulse_start();
    acc_q.delete();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    send_stream(stall_pct);
    t = 0;
    while (!(loadDone || loadError) && t < 20) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc;
    if (t >= 20) begin
      expect_eq({tag, "_end_timeout"}, 0, 1);
      return;
    end
    if (acc_q.size() != tx_q.size()) return;
    n = (int'(tx_q[0]) << 8) | int'(tx_q[1]);
    expect_eq({tag, "_byteReady_end"}, byteReady, 0);
    if (n == 0 || n > LENGTH) begin
      expect_eq({tag, "_writes"}, wr_addr.size(), 0);
      expect_eq({tag, "_end_cycle"}, done_cyc, acc_q[1]);
      expect_eq({tag, "_loadDone"}, loadDone, (n == 0));
      expect_eq({tag, "_loadError"}, loadError, (n > LENGTH));
      expect_eq({tag, "_holdCpu"}, holdCpu, (n > LENGTH));
    end else begin
      expect_eq({tag, "_writes"}, wr_addr.size(), n);
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
        logic [SIZE-1:0] w = '0;
        for (int j = 0; j < BPW; j++) w = (w << 8) | SIZE'(tx_q[2 + BPW * i + j]);
        expect_eq($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
        expect_eq($sformatf("%s_data%0d", tag, i), wr_data[i], w);
        expect_eq($sformatf("%s_wcyc%0d", tag, i), wr_cyc[i], acc_q[2 + BPW * i + BPW - 1]);
      end
      expect_eq({tag, "_done_cycle"}, done_cyc, acc_q[acc_q.size() - 1] + 1);
      expect_eq({tag, "_loadDone"}, loadDone, 1);
      expect_eq({tag, "_loadError"}, loadError, 0);
      expect_eq({tag, "_holdCpu"}, holdCpu, 0);
    end
  endtask

  task automatic build_random(input int n);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    for (int i = 0; i < n * BPW; i++) tx_q.push_back(8'($urandom_range(255)));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    load("basic", 0);

    tx_q = '{8'h00, 8'h00};
    load("empty", 0);

    tx_q = '{8'h01, 8'h01};
    load("oversize", 0);

    tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    load("after_err", 0);

    tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    load("stall", 50);

    for (int k = 0; k < 6; k++) begin
      build_random($urandom_range(1, 12));
      load($sformatf("rand%0d", k), $urandom_range(0, 70));
    end

    build_random(LENGTH);
    load("full", 20);

    build_random(LENGTH + 1);
    while (tx_q.size() > 2) void'(tx_q.pop_back());
    load("len_plus1", 0);

    pulse_start();
    tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD};
    acc_q.delete();
    send_stream(0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    expect_eq("start_with_reset_ignored", byteReady, 0);

    tx_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    load("post_reset", 30);

    expect_eq("we_back_to_back", back_to_back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
